// File: rtl/icache_direct_pkg.sv
// Shared pipeline definitions for the direct-mapped instruction cache:
// default geometry and FSM state encodings.
package icache_direct_pkg;

  localparam int ICACHE_LINES_DEF = 16;
  localparam int ICACHE_WORDS_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

endpackage

// File: rtl/icache_tag_store.sv
// Valid bits and tags for the instruction cache: combinational lookup,
// single-line write, one-cycle invalidate of every line.
module icache_tag_store #(
  parameter int LINES = 16,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inval_all
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

  // Invalidate wins over a simultaneous line write.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid <= '0;
    end else if (inval_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with blocking linear line refill.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINES  = ICACHE_LINES_DEF,
  parameter int WORDS  = ICACHE_WORDS_DEF,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [31:0]       o_instr,
  output logic              o_miss,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  localparam int OFF_B   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int CNT_W   = (OFF_B > 0) ? OFF_B : 1;
  localparam int LINE_SH = 2 + OFF_B;
  localparam int TAG_SH  = LINE_SH + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_SH;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              discard;
  logic [ADDR_W-1:0] line_base;
  logic [31:0]       data_mem [LINES][WORDS];

  logic [CNT_W-1:0]  cur_off;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              tag_hit;
  logic              in_idle;
  logic              lookup_hit;
  logic              lookup_miss;
  logic              last_word;
  logic              tag_wr;

  assign cur_off  = (OFF_B == 0) ? '0 : CNT_W'(i_addr >> 2);
  assign cur_idx  = IDX_W'(i_addr >> LINE_SH);
  assign cur_tag  = TAG_W'(i_addr >> TAG_SH);
  assign fill_idx = IDX_W'(line_base >> LINE_SH);
  assign fill_tag = TAG_W'(line_base >> TAG_SH);

  assign in_idle     = (state == ST_IDLE);
  assign lookup_hit  = in_idle && i_req && tag_hit;
  assign lookup_miss = in_idle && i_req && !tag_hit;
  assign last_word   = (cnt == CNT_W'(WORDS - 1));
  assign tag_wr      = (state == ST_UPDATE) && !discard && !i_flush;

  assign o_miss     = in_idle ? lookup_miss : 1'b1;
  assign o_instr    = lookup_hit ? data_mem[cur_idx][cur_off] : 32'd0;
  assign o_mem_req  = (state == ST_REFILL);
  assign o_mem_addr = o_mem_req ? (line_base + (ADDR_W'(cnt) << 2)) : '0;

  icache_tag_store #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tags (
    .Clk       (Clk),
    .Rst       (Rst),
    .lk_idx    (cur_idx),
    .lk_tag    (cur_tag),
    .lk_hit    (tag_hit),
    .wr_en     (tag_wr),
    .wr_idx    (fill_idx),
    .wr_tag    (fill_tag),
    .inval_all (i_flush)
  );

  // A flush during refill only marks the line as discarded; the handshake
  // still runs to the last word so memory never sees a dropped request.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      discard   <= 1'b0;
      line_base <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lookup_miss) begin
            line_base <= (i_addr >> LINE_SH) << LINE_SH;
            cnt       <= '0;
            state     <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (i_flush) begin
            discard <= 1'b1;
          end
          if (i_mem_ack) begin
            if (last_word) begin
              cnt   <= '0;
              state <= ST_UPDATE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          discard <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (o_mem_req && i_mem_ack) begin
      data_mem[fill_idx][cnt] <= i_mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (lookup_hit && (o_hit_cnt != 32'hFFFF_FFFF)) begin
        o_hit_cnt <= o_hit_cnt + 32'd1;
      end
      if (lookup_miss && (o_miss_cnt != 32'hFFFF_FFFF)) begin
        o_miss_cnt <= o_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: random fetches against a line-level
// cache model, with a memory responder that checks refill addresses.
module tb_icache_direct;

  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic [31:0] o_instr;
  logic        o_miss;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;
`endif

  icache_direct #(
    .LINES  (LINES),
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_flush    (i_flush),
    .o_instr    (o_instr),
    .o_miss     (o_miss),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .o_hit_cnt  (o_hit_cnt),
    .o_miss_cnt (o_miss_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    int          penalty;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [31:0] refill_q[$];
  int          mem_wait = 0;

  // Reference model: which memory block (addr / line bytes) each line holds.
  bit          m_valid [LINES];
  logic [31:0] m_block [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelFlush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic modelFetch(input logic [31:0] addr, input int w, input bit flush_now,
                            input bit flush_refill, output int penalty);
    logic [31:0] block;
    int          line;
    bit          hit;
    int          refills;
    block = addr / (4 * WORDS);
    line  = int'(block % LINES);
    hit   = m_valid[line] && (m_block[line] == block);
    if (flush_now || (flush_refill && !hit)) modelFlush();
    if (hit) begin
      penalty = 0;
    end else begin
      refills = flush_refill ? 2 : 1;
      for (int r = 0; r < refills; r++)
        for (int k = 0; k < WORDS; k++)
          refill_q.push_back(block * (4 * WORDS) + 4 * k);
      penalty = refills * (WORDS * (w + 1) + 2);
      m_valid[line] = 1'b1;
      m_block[line] = block;
    end
  endtask

  // One fetch: hold the request until the cache stops reporting a miss.
  task automatic applyStimulus(input logic [31:0] addr, input int w, input bit flush_now,
                               input bit flush_refill);
    int pen;
    int cycles;
    bit done;
    modelFetch(addr, w, flush_now, flush_refill, pen);
    exp_q.push_back('{data: mem_word(addr & ~32'h3), penalty: pen});
    mem_wait = w;
    i_addr   = addr;
    i_req    = 1'b1;
    i_flush  = flush_now;
    cycles   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge Clk);
      if (!o_miss) begin
        done = 1'b1;
      end else if (cycles >= 500) begin
        total++;
        bad++;
        $display("[TB] FAIL fetch_timeout: addr 0x%0h still missing after %0d cycles, want done", addr, cycles);
        done = 1'b1;
      end else begin
        @(posedge Clk);
        #1;
        cycles++;
        i_flush = flush_refill && (cycles == 2);
      end
    end
    @(posedge Clk);
    #1;
    i_flush = 1'b0;
  endtask

  task automatic idleCycle(input bit flush);
    i_req   = 1'b0;
    i_flush = flush;
    if (flush) modelFlush();
    @(posedge Clk);
    #1;
    i_flush = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the cache delivers an instruction.
  initial begin
    int   mcyc;
    exp_t e;
    mcyc = 0;
    forever begin
      @(negedge Clk);
      if (Rst && i_req) begin
        if (o_miss) begin
          mcyc++;
        end else begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_hit: instr 0x%0h with empty scoreboard", o_instr);
          end else begin
            e = exp_q.pop_front();
            checkOutput("instr", o_instr, e.data);
            checkOutput("miss_cycles", mcyc, e.penalty);
          end
          mcyc = 0;
        end
      end else begin
        mcyc = 0;
        if (Rst) begin
          checkOutput("idle_instr", o_instr, 32'd0);
          checkOutput("idle_miss", {31'd0, o_miss}, 32'd0);
        end
      end
    end
  end

  // Memory responder with configurable wait states and spurious acks while idle.
  initial begin
    int          wcnt;
    logic [31:0] held;
    wcnt = 0;
    held = '0;
    forever begin
      @(negedge Clk);
      if (!Rst || !o_mem_req) begin
        i_mem_ack  = Rst && ($urandom_range(0, 3) == 0);
        i_mem_data = $urandom;
        wcnt       = 0;
      end else begin
        if (wcnt > 0) checkOutput("addr_stable", o_mem_addr, held);
        held = o_mem_addr;
        if (wcnt >= mem_wait) begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem_word(o_mem_addr);
          wcnt       = 0;
          if (refill_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL extra_refill: addr 0x%0h requested, none expected", o_mem_addr);
          end else begin
            checkOutput("mem_addr", o_mem_addr, refill_q.pop_front());
          end
        end else begin
          i_mem_ack  = 1'b0;
          i_mem_data = $urandom;
          wcnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [31:0] tagv;
    int          pen;
    bit          fl_now;
    bit          fl_ref;

    modelFlush();
    Rst    = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h100;
    #3;
    checkOutput("rst_miss", {31'd0, o_miss}, 32'd1);
    checkOutput("rst_instr", o_instr, 32'd0);
    checkOutput("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    checkOutput("rst_mem_addr", o_mem_addr, 32'd0);
    i_req = 1'b0;
    #1;
    checkOutput("rst_miss_noreq", {31'd0, o_miss}, 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    applyStimulus(32'h100, 0, 1'b0, 1'b0);
    applyStimulus(32'h10C, 0, 1'b0, 1'b0);
    applyStimulus(32'h200, 0, 1'b0, 1'b0);
    applyStimulus(32'h100, 0, 1'b0, 1'b0);
    applyStimulus(32'h300, 3, 1'b0, 1'b0);
    applyStimulus(32'h140, 0, 1'b0, 1'b1);
    applyStimulus(32'h148, 0, 1'b0, 1'b0);
    idleCycle(1'b1);

    // Reset lands while word 2 of the line is outstanding.
    modelFetch(32'h100, 0, 1'b0, 1'b0, pen);
    mem_wait = 0;
    i_addr   = 32'h100;
    i_req    = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst   = 1'b0;
    i_req = 1'b0;
    #1;
    checkOutput("midrst_mem_req", {31'd0, o_mem_req}, 32'd0);
    checkOutput("midrst_mem_addr", o_mem_addr, 32'd0);
    refill_q.delete();
    modelFlush();
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    applyStimulus(32'h100, 0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 15))
        0:       idleCycle(1'b1);
        1, 2:    idleCycle(1'b0);
        default: ;
      endcase
      tagv = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tagv = tagv | 32'h0080_0000;
      addr = (tagv << 8) | (32'($urandom_range(0, 15)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fl_now = ($urandom_range(0, 15) == 0);
      fl_ref = !fl_now && ($urandom_range(0, 15) == 0);
      applyStimulus(addr, $urandom_range(0, 2), fl_now, fl_ref);
    end
    idleCycle(1'b0);

`ifdef ICACHE_STATS_EN
    Rst = 1'b0;
    modelFlush();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    applyStimulus(32'h100, 0, 1'b0, 1'b0);
    applyStimulus(32'h104, 0, 1'b0, 1'b0);
    applyStimulus(32'h108, 0, 1'b0, 1'b0);
    applyStimulus(32'h10C, 0, 1'b0, 1'b0);
    applyStimulus(32'h100, 0, 1'b0, 1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("stat_miss_cnt", o_miss_cnt, 32'd1);
    checkOutput("stat_hit_cnt", o_hit_cnt, 32'd5);
`endif

    repeat (2) idleCycle(1'b0);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    checkOutput("refills_drained", refill_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
